// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with runtime-selectable fixed or round-robin arbitration.
// The result (code, one-hot grant, multi-request flag) sits in an output register behind a valid/ready handshake.
module priority_encoder_rr #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             code_ready,
    output logic             code_valid,
    output logic [IDX_W-1:0] code,
    output logic [N-1:0]     grant,
    output logic             multi
);

    logic             r_valid;
    logic [IDX_W-1:0] r_code;
    logic [N-1:0]     r_grant;
    logic             r_multi;
    logic [IDX_W-1:0] r_ptr;

    logic             w_accept;
    logic             w_loadEn;
    logic [IDX_W-1:0] w_nextIdx;
    logic [IDX_W-1:0] w_start;
    logic             w_hit;
    logic [IDX_W-1:0] w_sel;
    logic             w_multi;

    assign w_accept  = r_valid & code_ready;
    assign w_loadEn  = ~r_valid | w_accept;
    // Explicit wrap so non-power-of-two N never produces an out-of-range index.
    assign w_nextIdx = (r_code == IDX_W'(N - 1)) ? '0 : r_code + IDX_W'(1);
    assign w_start   = w_accept ? w_nextIdx : r_ptr;
    assign w_multi   = (req & (req - N'(1))) != '0;

    // Search from w_start (round-robin) or from 0 (fixed); first hit wins.
    always_comb begin
        int idx;
        logic [IDX_W-1:0] cand;
        w_hit = 1'b0;
        w_sel = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            if (mode) begin
                idx = int'(w_start) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end else begin
                idx = k;
            end
            cand = IDX_W'(idx);
            if (!w_hit && req[cand]) begin
                w_hit = 1'b1;
                w_sel = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_grant <= '0;
            r_multi <= 1'b0;
            r_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_nextIdx;
            end
            if (w_loadEn) begin
                if (w_hit) begin
                    r_valid <= 1'b1;
                    r_code  <= w_sel;
                    r_grant <= N'(1) << w_sel;
                    r_multi <= w_multi;
                end else begin
                    r_valid <= 1'b0;
                    r_code  <= '0;
                    r_grant <= '0;
                    r_multi <= 1'b0;
                end
            end
        end
    end

    assign code_valid = r_valid;
    assign code       = r_code;
    assign grant      = r_grant;
    assign multi      = r_multi;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Scenario-driven bench for priority_encoder_rr: an N=8 instance and an N=5 instance for the non-power-of-two wrap.
// Expected results are queued when stimulus is driven and popped when the registered output appears.
module tb_priority_encoder_rr;

    typedef struct packed {
        logic       v;
        logic [2:0] c;
        logic [7:0] g;
        logic       m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] req = '0;
    logic       mode = 1'b0;
    logic       codeReady = 1'b0;
    logic       codeValid;
    logic [2:0] code;
    logic [7:0] grant;
    logic       multi;

    logic [4:0] req5 = '0;
    logic       mode5 = 1'b0;
    logic       codeReady5 = 1'b0;
    logic       codeValid5;
    logic [2:0] code5;
    logic [4:0] grant5;
    logic       multi5;

    exp_t sb[$];
    exp_t sb5[$];
    int   nChecks = 0;
    int   nFails  = 0;

    priority_encoder_rr #(.N(8), .IDX_W(3)) dut8 (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .code_ready(codeReady),
        .code_valid(codeValid), .code(code), .grant(grant), .multi(multi)
    );

    priority_encoder_rr #(.N(5), .IDX_W(3)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .mode(mode5), .code_ready(codeReady5),
        .code_valid(codeValid5), .code(code5), .grant(grant5), .multi(multi5)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge, inputs are changed there too.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b1;
        req = '0; mode = 1'b0; codeReady = 1'b0;
        req5 = '0; mode5 = 1'b0; codeReady5 = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e, got;
        #6;
        sb.push_back(exp_t'{1'b0, 3'd0, 8'h00, 1'b0});
        e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
        if (got !== e) begin
            nFails++;
            $display("[TB] FAIL reset_state: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
        end
        rst = 1'b0;
        req = 8'h10;
        sb.push_back(exp_t'{1'b1, 3'd4, 8'h10, 1'b0});
        tick();
        e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
        if (got !== e) begin
            nFails++;
            $display("[TB] FAIL reset_preload: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
        end
        #2;
        rst = 1'b1;
        sb.push_back(exp_t'{1'b0, 3'd0, 8'h00, 1'b0});
        #1;
        e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
        if (got !== e) begin
            nFails++;
            $display("[TB] FAIL reset_async: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
        end
        rst = 1'b0;
        req = 8'h00;
        sb.push_back(exp_t'{1'b0, 3'd0, 8'h00, 1'b0});
        tick();
        e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
        if (got !== e) begin
            nFails++;
            $display("[TB] FAIL reset_release_idle: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
        end
    endtask

    task automatic test_fixed;
        exp_t e, got;
        logic [7:0] reqs [3] = '{8'hC8, 8'h40, 8'h00};
        exp_t       exps [3] = '{exp_t'{1'b1, 3'd3, 8'h08, 1'b1},
                                 exp_t'{1'b1, 3'd6, 8'h40, 1'b0},
                                 exp_t'{1'b0, 3'd0, 8'h00, 1'b0}};
        doReset();
        mode = 1'b0; codeReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = reqs[i];
            sb.push_back(exps[i]);
            tick();
            e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL fixed_step%0d: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", i, got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
            end
        end
    endtask

    task automatic test_stall;
        exp_t e, got;
        doReset();
        mode = 1'b0; codeReady = 1'b0;
        req = 8'hC8;
        sb.push_back(exp_t'{1'b1, 3'd3, 8'h08, 1'b1});
        tick();
        e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
        if (got !== e) begin
            nFails++;
            $display("[TB] FAIL stall_load: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
        end
        req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            mode = i[0];
            sb.push_back(exp_t'{1'b1, 3'd3, 8'h08, 1'b1});
            tick();
            e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL stall_hold%0d: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", i, got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
            end
        end
        mode = 1'b0;
        codeReady = 1'b1;
        sb.push_back(exp_t'{1'b1, 3'd0, 8'h01, 1'b0});
        tick();
        e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
        if (got !== e) begin
            nFails++;
            $display("[TB] FAIL stall_release: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e, got;
        doReset();
        mode = 1'b1; codeReady = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(exp_t'{1'b1, 3'(i % 8), 8'h01 << (i % 8), 1'b1});
            tick();
            e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL rr_sweep%0d: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", i, got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
            end
        end
    endtask

    task automatic test_wrap;
        exp_t e, got;
        logic [7:0] reqs [4] = '{8'h20, 8'h05, 8'h05, 8'h05};
        exp_t       exps [4] = '{exp_t'{1'b1, 3'd5, 8'h20, 1'b0},
                                 exp_t'{1'b1, 3'd0, 8'h01, 1'b1},
                                 exp_t'{1'b1, 3'd2, 8'h04, 1'b1},
                                 exp_t'{1'b1, 3'd0, 8'h01, 1'b1}};
        doReset();
        mode = 1'b1; codeReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = reqs[i];
            sb.push_back(exps[i]);
            tick();
            e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL rr_wrap%0d: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", i, got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
            end
        end
    endtask

    // Pointer keeps advancing in fixed mode, so returning to round-robin resumes after the last served index.
    task automatic test_mode_switch;
        exp_t e, got;
        logic       modes [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       rdys  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] codes [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd1};
        doReset();
        req = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            mode = modes[i];
            codeReady = rdys[i];
            sb.push_back(exp_t'{1'b1, codes[i], 8'h01 << codes[i], 1'b1});
            tick();
            e = sb.pop_front(); got = {codeValid, code, grant, multi}; nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL mode_switch%0d: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", i, got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
            end
        end
    endtask

    task automatic test_n5_wrap;
        exp_t e, got;
        doReset();
        mode5 = 1'b1; codeReady5 = 1'b1; req5 = 5'b10001;
        for (int i = 0; i < 5; i++) begin
            if (i[0]) sb5.push_back(exp_t'{1'b1, 3'd4, 8'h10, 1'b1});
            else      sb5.push_back(exp_t'{1'b1, 3'd0, 8'h01, 1'b1});
            tick();
            e = sb5.pop_front(); got = {codeValid5, code5, {3'b000, grant5}, multi5}; nChecks++;
            if (got !== e) begin
                nFails++;
                $display("[TB] FAIL n5_alt%0d: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", i, got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
            end
        end
        req5 = 5'b01000;
        sb5.push_back(exp_t'{1'b1, 3'd3, 8'h08, 1'b0});
        tick();
        e = sb5.pop_front(); got = {codeValid5, code5, {3'b000, grant5}, multi5}; nChecks++;
        if (got !== e) begin
            nFails++;
            $display("[TB] FAIL n5_single: got v=%0b code=%0d grant=%h multi=%0b, expected v=%0b code=%0d grant=%h multi=%0b", got.v, got.c, got.g, got.m, e.v, e.c, e.g, e.m);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_mode_switch();
        test_n5_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
